// File: rtl/fft_frame_sequencer.sv
// Drives one frame through the serial FFT core: core reset, sample load, watchdog wait, bin unload.
// Optional macro SEQ_LAT_MEAS_EN adds the lat_cnt latency-measurement output.
module fft_frame_sequencer #(
   parameter  int FFT_SIZE  = 32,
   parameter  int IN_W      = 12,
   parameter  int OUT_W     = 16,
   parameter  int LAT_LIMIT = 68,
   parameter  int RST_CYC   = 2,
   localparam int AW        = $clog2(FFT_SIZE)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             timeout_err,
   output logic             smp_rd,
   output logic [AW-1:0]    smp_addr,
   input  logic [IN_W-1:0]  smp_r,
   input  logic [IN_W-1:0]  smp_i,
   output logic             fft_rst_n,
   output logic             fft_in_valid,
   output logic [IN_W-1:0]  fft_din_r,
   output logic [IN_W-1:0]  fft_din_i,
   input  logic             fft_out_valid,
   input  logic [OUT_W-1:0] fft_dout_r,
   input  logic [OUT_W-1:0] fft_dout_i,
   output logic             bin_wr,
   output logic [AW-1:0]    bin_addr,
   output logic [OUT_W-1:0] bin_r,
   output logic [OUT_W-1:0] bin_i
`ifdef SEQ_LAT_MEAS_EN
   ,
   output logic [7:0]       lat_cnt
`endif
);

   localparam int WD_W = $clog2(LAT_LIMIT + 2);
   localparam int RC_W = $clog2(RST_CYC + 1);

   localparam logic [AW:0]     CNT_FULL = (AW+1)'(FFT_SIZE);
   localparam logic [AW:0]     CNT_LAST = (AW+1)'(FFT_SIZE - 1);
   localparam logic [WD_W-1:0] WD_MAX   = WD_W'(LAT_LIMIT);
   localparam logic [RC_W-1:0] RST_LAST = RC_W'(RST_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FRST,
      S_LOAD,
      S_WAIT,
      S_UNLOAD,
      S_FIN
   } state_t;

   state_t          state;
   logic [RC_W-1:0] rst_cnt;
   logic [AW:0]     rd_cnt;
   logic [AW:0]     in_cnt;
   logic [AW:0]     cap_cnt;
   logic [WD_W-1:0] wd;
   logic            rd_d1;

   // NOTE: every register, including the counters, is reset so an aborted frame leaves no stale state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         rst_cnt      <= '0;
         rd_cnt       <= '0;
         in_cnt       <= '0;
         cap_cnt      <= '0;
         wd           <= '0;
         rd_d1        <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         timeout_err  <= 1'b0;
         smp_rd       <= 1'b0;
         smp_addr     <= '0;
         fft_rst_n    <= 1'b1;
         fft_in_valid <= 1'b0;
         fft_din_r    <= '0;
         fft_din_i    <= '0;
         bin_wr       <= 1'b0;
         bin_addr     <= '0;
         bin_r        <= '0;
         bin_i        <= '0;
`ifdef SEQ_LAT_MEAS_EN
         lat_cnt      <= '0;
`endif
      end else begin
         done   <= 1'b0;
         bin_wr <= 1'b0;

         // Sample data arrives the cycle after the read strobe and is re-registered toward the core.
         rd_d1        <= smp_rd;
         fft_in_valid <= rd_d1;
         fft_din_r    <= rd_d1 ? smp_r : '0;
         fft_din_i    <= rd_d1 ? smp_i : '0;
         if (rd_d1) in_cnt <= in_cnt + 1'b1;

         case (state)
            S_IDLE: begin
               if (start) begin
                  state       <= S_FRST;
                  busy        <= 1'b1;
                  timeout_err <= 1'b0;
                  fft_rst_n   <= 1'b0;
                  rst_cnt     <= '0;
               end
            end

            S_FRST: begin
               if (rst_cnt == RST_LAST) begin
                  state     <= S_LOAD;
                  fft_rst_n <= 1'b1;
                  smp_rd    <= 1'b1;
                  smp_addr  <= '0;
                  rd_cnt    <= (AW+1)'(1);
                  in_cnt    <= '0;
               end else begin
                  rst_cnt <= rst_cnt + 1'b1;
               end
            end

            S_LOAD: begin
               if (smp_rd) begin
                  if (rd_cnt == CNT_FULL) begin
                     smp_rd <= 1'b0;
                  end else begin
                     smp_addr <= rd_cnt[AW-1:0];
                     rd_cnt   <= rd_cnt + 1'b1;
                  end
               end
               if (fft_in_valid && in_cnt == CNT_FULL) begin
                  state <= S_WAIT;
                  wd    <= WD_W'(1);
               end
            end

            // Watchdog expiry wins over a late out_valid arriving in the same cycle.
            S_WAIT: begin
               if (wd > WD_MAX) begin
                  state       <= S_FIN;
                  timeout_err <= 1'b1;
                  done        <= 1'b1;
                  busy        <= 1'b0;
               end else if (fft_out_valid) begin
                  state    <= S_UNLOAD;
                  cap_cnt  <= (AW+1)'(1);
                  bin_wr   <= 1'b1;
                  bin_addr <= '0;
                  bin_r    <= fft_dout_r;
                  bin_i    <= fft_dout_i;
`ifdef SEQ_LAT_MEAS_EN
                  lat_cnt  <= (32'(wd) > 32'd255) ? 8'd255 : 8'(wd);
`endif
               end else begin
                  wd <= wd + 1'b1;
               end
            end

            // The core streams a full frame once started, so out_valid is not re-checked here.
            S_UNLOAD: begin
               bin_wr   <= 1'b1;
               bin_addr <= cap_cnt[AW-1:0];
               bin_r    <= fft_dout_r;
               bin_i    <= fft_dout_i;
               cap_cnt  <= cap_cnt + 1'b1;
               if (cap_cnt == CNT_LAST) begin
                  state <= S_FIN;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end
            end

            S_FIN:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Randomized bench for fft_frame_sequencer: models the sample buffer and the FFT core and
// predicts every strobe, address, data word and completion cycle from the frame timing rules.
module tb_fft_frame_sequencer;

   localparam int FFT_SIZE  = 32;
   localparam int IN_W      = 12;
   localparam int OUT_W     = 16;
   localparam int LAT_LIMIT = 68;
   localparam int RST_CYC   = 2;
   localparam int AW        = 5;

   logic             clk;
   logic             rst;
   logic             start;
   logic             busy;
   logic             done;
   logic             timeout_err;
   logic             smp_rd;
   logic [AW-1:0]    smp_addr;
   logic [IN_W-1:0]  smp_r;
   logic [IN_W-1:0]  smp_i;
   logic             fft_rst_n;
   logic             fft_in_valid;
   logic [IN_W-1:0]  fft_din_r;
   logic [IN_W-1:0]  fft_din_i;
   logic             fft_out_valid;
   logic [OUT_W-1:0] fft_dout_r;
   logic [OUT_W-1:0] fft_dout_i;
   logic             bin_wr;
   logic [AW-1:0]    bin_addr;
   logic [OUT_W-1:0] bin_r;
   logic [OUT_W-1:0] bin_i;
`ifdef SEQ_LAT_MEAS_EN
   logic [7:0]       lat_cnt;
`endif

   fft_frame_sequencer #(
      .FFT_SIZE (FFT_SIZE),
      .IN_W     (IN_W),
      .OUT_W    (OUT_W),
      .LAT_LIMIT(LAT_LIMIT),
      .RST_CYC  (RST_CYC)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .busy         (busy),
      .done         (done),
      .timeout_err  (timeout_err),
      .smp_rd       (smp_rd),
      .smp_addr     (smp_addr),
      .smp_r        (smp_r),
      .smp_i        (smp_i),
      .fft_rst_n    (fft_rst_n),
      .fft_in_valid (fft_in_valid),
      .fft_din_r    (fft_din_r),
      .fft_din_i    (fft_din_i),
      .fft_out_valid(fft_out_valid),
      .fft_dout_r   (fft_dout_r),
      .fft_dout_i   (fft_dout_i),
      .bin_wr       (bin_wr),
      .bin_addr     (bin_addr),
      .bin_r        (bin_r),
      .bin_i        (bin_i)
`ifdef SEQ_LAT_MEAS_EN
      ,
      .lat_cnt      (lat_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec   = 0;
   int n_bad   = 0;
   int cyc     = 0;
   int exp_lat = 0;

   logic [IN_W-1:0]  mem_r [FFT_SIZE];
   logic [IN_W-1:0]  mem_i [FFT_SIZE];
   logic [OUT_W-1:0] exp_r [FFT_SIZE];
   logic [OUT_W-1:0] exp_i [FFT_SIZE];
   logic             prev_rd   = 1'b0;
   int               prev_addr = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Advance one cycle; outputs are then stable and the sample buffer answers last cycle's read.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (prev_rd) begin
         smp_r = mem_r[prev_addr];
         smp_i = mem_i[prev_addr];
      end else begin
         smp_r = IN_W'($urandom);
         smp_i = IN_W'($urandom);
      end
      prev_rd   = smp_rd;
      prev_addr = int'(smp_addr);
   endtask

   task automatic fill_frame();
      for (int i = 0; i < FFT_SIZE; i++) begin
         mem_r[i] = IN_W'($urandom);
         mem_i[i] = IN_W'($urandom);
         exp_r[i] = OUT_W'($urandom);
         exp_i[i] = OUT_W'($urandom);
      end
   endtask

   task automatic check_reset();
      check("rst_ctl", {busy, done, timeout_err, smp_rd, fft_rst_n, fft_in_valid, bin_wr}, 7'b0000100);
      check("rst_addr", {smp_addr, bin_addr}, '0);
      check("rst_din", {fft_din_r, fft_din_i}, '0);
      check("rst_bin", {bin_r, bin_i}, '0);
`ifdef SEQ_LAT_MEAS_EN
      check("rst_lat", lat_cnt, 0);
`endif
   endtask

   task automatic idle_check(input int n);
      start         = 1'b0;
      fft_out_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         step();
         check("idle_busy", busy, 0);
         check("idle_rd", smp_rd, 0);
         check("idle_done", done, 0);
      end
   endtask

   // lat < 0: core never answers. hold keeps start high throughout; inject toggles it randomly
   // (and forces it in the FIN cycle); after_fin means the call begins in a FIN cycle with start high.
   task automatic run_frame(input int lat, input bit hold, input bit inject, input bit after_fin);
      int s, first_rd, last_in, first_out, exp_done, out_k;
      int n_rd, n_in, n_rst, n_wr;
      bit exp_to, got_done;
      fill_frame();
      exp_to    = (lat < 0) || (lat > LAT_LIMIT);
      n_rd = 0; n_in = 0; n_rst = 0; n_wr = 0;
      last_in   = -1;
      first_out = -1;
      exp_done  = -1;
      out_k     = FFT_SIZE;
      got_done  = 1'b0;
      if (after_fin) s = cyc + 1;
      else begin
         s     = cyc;
         start = 1'b1;
      end
      first_rd = s + 1 + RST_CYC;
      for (int t = 0; t < 400 && !got_done; t++) begin
         step();
         if (cyc > s && !done) begin
            check("busy", busy, 1);
            check("err_clr", timeout_err, 0);
         end
         if (!fft_rst_n) begin
            check("frst_cyc", cyc, s + 1 + n_rst);
            n_rst++;
         end
         if (smp_rd) begin
            check("smp_addr", smp_addr, n_rd);
            check("rd_cyc", cyc, first_rd + n_rd);
            n_rd++;
         end
         if (fft_in_valid) begin
            if (n_in < FFT_SIZE) begin
               check("din_r", fft_din_r, mem_r[n_in]);
               check("din_i", fft_din_i, mem_i[n_in]);
               check("in_cyc", cyc, first_rd + 2 + n_in);
            end else check("in_extra", n_in, FFT_SIZE - 1);
            n_in++;
            if (n_in == FFT_SIZE) begin
               last_in  = cyc;
               exp_done = exp_to ? cyc + LAT_LIMIT + 2 : cyc + lat + FFT_SIZE;
               if (!exp_to) first_out = cyc + lat;
            end
         end
         if (bin_wr) begin
            if (n_wr < FFT_SIZE) begin
               check("bin_addr", bin_addr, n_wr);
               check("bin_r", bin_r, exp_r[n_wr]);
               check("bin_i", bin_i, exp_i[n_wr]);
               check("wr_cyc", cyc, first_out + 1 + n_wr);
            end else check("wr_extra", n_wr, FFT_SIZE - 1);
            n_wr++;
         end
         if (done) begin
            got_done = 1'b1;
            check("done_cyc", cyc, exp_done);
            check("timeout_err", timeout_err, exp_to);
            check("busy_fin", busy, 0);
            check("n_rd", n_rd, FFT_SIZE);
            check("n_in", n_in, FFT_SIZE);
            check("n_rst", n_rst, RST_CYC);
            check("n_wr", n_wr, exp_to ? 0 : FFT_SIZE);
            if (!exp_to) exp_lat = (lat > 255) ? 255 : lat;
`ifdef SEQ_LAT_MEAS_EN
            check("lat_cnt", lat_cnt, exp_lat);
`endif
         end

         if (cyc <= s)    start = 1'b1;
         else if (inject) start = (cyc == exp_done) ? 1'b1 : 1'($urandom);
         else             start = hold;

         if (last_in >= 0 && lat >= 0 && cyc == last_in + lat) out_k = 0;
         if (out_k < FFT_SIZE) begin
            fft_out_valid = (out_k == 0) ? 1'b1 : 1'($urandom);
            fft_dout_r    = exp_r[out_k];
            fft_dout_i    = exp_i[out_k];
            out_k++;
         end else begin
            // Spurious core output before the load completes must not start an unload.
            fft_out_valid = (last_in < 0 && cyc > s) ? ($urandom_range(0, 3) == 0) : 1'b0;
            fft_dout_r    = OUT_W'($urandom);
            fft_dout_i    = OUT_W'($urandom);
         end
      end
      if (!got_done) check("frame_end", 0, 1);
   endtask

   initial begin
      bit found;
      rst           = 1'b1;
      start         = 1'b0;
      smp_r         = '0;
      smp_i         = '0;
      fft_out_valid = 1'b0;
      fft_dout_r    = '0;
      fft_dout_i    = '0;
      repeat (2) step();
      check_reset();
      rst = 1'b0;
      idle_check(2);

      // Abort in the middle of the sample load.
      fill_frame();
      start = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         step();
         start = 1'b0;
         if (smp_rd && smp_addr == AW'(10)) found = 1'b1;
      end
      check("reach_s10", found, 1);
      rst = 1'b1;
      step();
      check_reset();
      step();
      check("rst_no_done", done, 0);
      rst = 1'b0;
      idle_check(4);

      run_frame(40, 1'b0, 1'b0, 1'b0);
      idle_check(3);
      for (int i = 0; i < 5; i++) begin
         run_frame(int'($urandom_range(1, LAT_LIMIT)), 1'b0, 1'($urandom), 1'b0);
         idle_check(3);
      end
      run_frame(LAT_LIMIT, 1'b0, 1'b0, 1'b0);
      idle_check(3);
      run_frame(LAT_LIMIT + 1, 1'b0, 1'b0, 1'b0);
      idle_check(3);
      run_frame(-1, 1'b0, 1'b0, 1'b0);
      idle_check(3);
      run_frame(30, 1'b0, 1'b1, 1'b0);
      idle_check(40);
      run_frame(-1, 1'b1, 1'b0, 1'b0);
      run_frame(40, 1'b0, 1'b0, 1'b1);
      idle_check(3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
